// File: rtl/stopwatch_timebase.sv
// Stopwatch timekeeping core: button synchronisers, run/pause/idle control,
// one-second prescaler, MM:SS counter with saturation and a lap-freeze display.
module stopwatch_timebase #(
  parameter int TICK_DIV    = 50000000,
  parameter int MAX_MINUTES = 99
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [6:0] minutes,
  output logic [6:0] seconds,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  localparam int              PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [6:0]      MIN_LAST   = 7'(MAX_MINUTES);
  localparam logic [6:0]      SEC_LAST   = 7'd59;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  // Bit order for the button vectors: [0] start_stop, [1] lap, [2] clear.
  logic [2:0]    sync1_q, sync2_q, prev_q;
  logic [2:0]    btn_pulse;
  logic          ss_p, clr_p, lap_p;
  logic          tick;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    min_q, min_d, sec_q, sec_d;
  logic [6:0]    snap_min_q, snap_min_d, snap_sec_q, snap_sec_d;
  logic [6:0]    min_out_q, min_out_d, sec_out_q, sec_out_d;
  logic          lap_q, lap_d, ovf_q, ovf_d;

  assign btn_pulse = sync2_q & ~prev_q;
  assign ss_p      = btn_pulse[0];
  assign clr_p     = btn_pulse[2] & ~btn_pulse[0];
  assign lap_p     = btn_pulse[1] & ~btn_pulse[0] & ~btn_pulse[2];

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    min_d      = min_q;
    sec_d      = sec_q;
    snap_min_d = snap_min_q;
    snap_sec_d = snap_sec_q;
    lap_d      = lap_q;
    ovf_d      = ovf_q;
    tick       = 1'b0;

    case (state_q)
      IDLE: begin
        if (ss_p) state_d = RUN;
      end
      RUN: begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          if (sec_q < SEC_LAST) begin
            sec_d = sec_q + 7'd1;
          end else if (min_q < MIN_LAST) begin
            sec_d = '0;
            min_d = min_q + 7'd1;
          end else begin
            state_d = PAUSE;
            ovf_d   = 1'b1;
          end
        end
        // A start_stop in a tick cycle still keeps that tick.
        if (ss_p) begin
          state_d = PAUSE;
        end else if (lap_p) begin
          lap_d = ~lap_q;
          if (!lap_q) begin
            snap_min_d = min_q;
            snap_sec_d = sec_q;
          end
        end
      end
      PAUSE: begin
        if (ss_p) begin
          if (!ovf_q) state_d = RUN;
        end else if (clr_p) begin
          state_d = IDLE;
          presc_d = '0;
          min_d   = '0;
          sec_d   = '0;
          lap_d   = 1'b0;
          ovf_d   = 1'b0;
        end else if (lap_p) begin
          lap_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    min_out_d = lap_q ? snap_min_q : min_q;
    sec_out_d = lap_q ? snap_sec_q : sec_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      state_q    <= IDLE;
      presc_q    <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      snap_min_q <= '0;
      snap_sec_q <= '0;
      min_out_q  <= '0;
      sec_out_q  <= '0;
      lap_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sync1_q    <= {btn_clear, btn_lap, btn_start_stop};
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      state_q    <= state_d;
      presc_q    <= presc_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      snap_min_q <= snap_min_d;
      snap_sec_q <= snap_sec_d;
      min_out_q  <= min_out_d;
      sec_out_q  <= sec_out_d;
      lap_q      <= lap_d;
      ovf_q      <= ovf_d;
    end
  end

  assign minutes    = min_out_q;
  assign seconds    = sec_out_q;
  assign running    = (state_q == RUN);
  assign lap_active = lap_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Directed bench for stopwatch_timebase with TICK_DIV=4: a vector table for
// the basic run sequence plus hand-timed sequences for the multi-cycle cases.
module tb_stopwatch_timebase;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start_stop = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_clear = 1'b0;
  logic [6:0] minutes, seconds;
  logic       running, lap_active, overflow;

  int checks = 0;
  int errors = 0;

  stopwatch_timebase #(.TICK_DIV(4), .MAX_MINUTES(99)) dut (
    .clock          (clock),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_lap        (btn_lap),
    .btn_clear      (btn_clear),
    .minutes        (minutes),
    .seconds        (seconds),
    .running        (running),
    .lap_active     (lap_active),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic ss, lap, clr;
    int   n;
    int   m, s;
    logic run, lp, ov;
  } vec_t;

  vec_t vecs[9];

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int m, input int s,
                         input int run, input int lp, input int ov);
    chk({tag, ".minutes"},    int'(minutes),    m);
    chk({tag, ".seconds"},    int'(seconds),    s);
    chk({tag, ".running"},    int'(running),    run);
    chk({tag, ".lap_active"}, int'(lap_active), lp);
    chk({tag, ".overflow"},   int'(overflow),   ov);
  endtask

  // One-cycle button press: button rises before the next edge.
  task automatic press(input logic ss, input logic lap, input logic clr);
    btn_start_stop = ss;
    btn_lap        = lap;
    btn_clear      = clr;
    step(1);
    btn_start_stop = 1'b0;
    btn_lap        = 1'b0;
    btn_clear      = 1'b0;
  endtask

  task automatic do_reset();
    btn_start_stop = 1'b0;
    btn_lap        = 1'b0;
    btn_clear      = 1'b0;
    reset          = 1'b1;
    step(2);
    reset          = 1'b0;
  endtask

  initial begin
    //          ss    lap   clr   n    m  s   run   lp    ov
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1,   0, 0,  1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1,   0, 0,  1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1,   0, 0,  1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1,   0, 0,  1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 4,   0, 0,  1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1,   0, 1,  1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 235, 0, 59, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1,   1, 0,  1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 3,   1, 0,  1'b1, 1'b0, 1'b0};

    // Basic run from reset: start latency, first tick, minute rollover.
    do_reset();
    chk_all("reset", 0, 0, 0, 0, 0);
    for (int unsigned i = 0; i < 9; i++) begin
      press(vecs[i].ss, vecs[i].lap, vecs[i].clr);
      if (vecs[i].n > 1) step(vecs[i].n - 1);
      chk_all($sformatf("vec%0d", i), vecs[i].m, vecs[i].s,
              int'(vecs[i].run), int'(vecs[i].lp), int'(vecs[i].ov));
    end

    // Pause at 00:07 mid-second; resume finishes the partial second.
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    step(29);
    press(1'b1, 1'b0, 1'b0);
    step(1);
    chk_all("pause_pre", 0, 7, 1, 0, 0);
    step(1);
    chk("pause_state.running", int'(running), 0);
    step(20);
    chk_all("paused", 0, 7, 0, 0, 0);
    press(1'b1, 1'b0, 1'b0);
    step(2);
    chk("resume.running", int'(running), 1);
    step(2);
    chk("resume_early.seconds", int'(seconds), 7);
    step(1);
    chk("resume_tick.seconds", int'(seconds), 8);

    // Lap freeze at 00:03 while the internal count keeps going.
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    step(13);
    press(1'b0, 1'b1, 1'b0);
    step(2);
    chk_all("lap_on", 0, 3, 1, 1, 0);
    step(39);
    chk_all("lap_frozen", 0, 3, 1, 1, 0);
    press(1'b0, 1'b1, 1'b0);
    step(2);
    chk_all("lap_off", 0, 3, 1, 0, 0);
    step(1);
    chk_all("lap_live", 0, 14, 1, 0, 0);

    // Clear ignored while running; clear from pause at 01:05.
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    step(99);
    press(1'b0, 1'b0, 1'b1);
    step(3);
    chk_all("clr_running", 0, 25, 1, 0, 0);
    step(158);
    press(1'b1, 1'b0, 1'b0);
    step(2);
    chk("pause_105.running", int'(running), 0);
    step(1);
    chk_all("paused_105", 1, 5, 0, 0, 0);
    press(1'b0, 1'b0, 1'b1);
    step(2);
    chk_all("clr_edge", 1, 5, 0, 0, 0);
    step(1);
    chk_all("cleared", 0, 0, 0, 0, 0);

    // From IDLE: run, pause at 00:01, then start_stop+clear together resumes.
    press(1'b1, 1'b0, 1'b0);
    step(4);
    press(1'b1, 1'b0, 1'b0);
    step(2);
    chk("pause_01.running", int'(running), 0);
    step(1);
    chk_all("paused_01", 0, 1, 0, 0, 0);
    step(2);
    press(1'b1, 1'b0, 1'b1);
    step(2);
    chk("simul.running", int'(running), 1);
    step(1);
    chk_all("simul_count", 0, 1, 1, 0, 0);

    // Async reset mid-second with a button held through it.
    step(1);
    btn_start_stop = 1'b1;
    reset          = 1'b1;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0);
    step(4);
    chk_all("held_in_reset", 0, 0, 0, 0, 0);
    btn_start_stop = 1'b0;
    step(1);
    reset = 1'b0;
    step(5);
    chk_all("post_reset", 0, 0, 0, 0, 0);

    // Saturation at 99:59: overflow, forced pause, start_stop locked out.
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    step(23995);
    chk_all("sat_9958", 99, 58, 1, 0, 0);
    step(4);
    chk_all("sat_9959", 99, 59, 1, 0, 0);
    step(3);
    chk("sat_edge.running", int'(running), 0);
    chk("sat_edge.overflow", int'(overflow), 1);
    step(1);
    chk_all("sat_hold", 99, 59, 0, 0, 1);
    press(1'b1, 1'b0, 1'b0);
    step(8);
    chk_all("sat_ss_ignored", 99, 59, 0, 0, 1);
    press(1'b0, 1'b0, 1'b1);
    step(3);
    chk_all("sat_cleared", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
